instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32 I/S/B fields into 32-bit words, range-checks
// the immediate, and queues {word, byte address} in a 2-entry FIFO.
// Rejected requests raise a one-cycle error pulse and bump a saturating count.
module instruction_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [63:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam logic [1:0] FMT_IALU  = 2'b00;
    localparam logic [1:0] FMT_ILOAD = 2'b01;
    localparam logic [1:0] FMT_STORE = 2'b10;

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_ILOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t            mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;

    logic              legal, accept, push, pop;
    logic [31:0]       word;

    // Ready only on free space; a pop in the same cycle does not free a slot early.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;

    // Immediate must fit the signed field of the chosen format; branches need even offsets.
    always_comb begin
        legal = 1'b0;
        if (fmt == 2'b11)
            legal = ((&imm[63:12]) | ~(|imm[63:12])) & ~imm[0];
        else
            legal = (&imm[63:11]) | ~(|imm[63:11]);
    end

    // Field packing for the four supported formats.
    always_comb begin
        word = '0;
        case (fmt)
            FMT_IALU:  word = {imm[11:0], rs1, funct3, rd, OP_IALU};
            FMT_ILOAD: word = {imm[11:0], rs1, funct3, rd, OP_ILOAD};
            FMT_STORE: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            default:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        endcase
    end

    // Two-entry FIFO; push is only ever issued when a slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{word: word, addr: addr_cnt};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign instr    = out_valid ? mem[rd_ptr].word : 32'd0;
    assign out_addr = out_valid ? mem[rd_ptr].addr : '0;

    // Address counter: clear wins over increment; a same-cycle push still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_cnt <= '0;
        else if (addr_clr)
            addr_cnt <= '0;
        else if (push)
            addr_cnt <= addr_cnt + ADDR_W'(4);
    end

    // Rejection reporting: pulse for one cycle, count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= accept & ~legal;
            if (accept && !legal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
